// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the memory-side port of the
// memory port arbiter.
//   fetch  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata[31:0]
//   data   : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata[63:0]
//   memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   status : busy
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters and memory model)
// Handshake: a requester raises req with stable fields and holds them until
// the cycle its gnt is high; gnt is a one-cycle combinational pulse, and the
// request is accepted on the rising edge that ends that cycle. rvalid is a
// one-cycle pulse with rdata valid in the same cycle (rdata then holds).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [63:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   logic        busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. Exactly one access is outstanding at a time:
//   IDLE  -> grant (combinational), latch request, go ISSUE
//   ISSUE -> one cycle with mem_en=1; writes return to IDLE, reads go WAIT
//   WAIT  -> count down MEM_LAT, capture mem_rdata, pulse owner's rvalid
// Parameter MEM_LAT (1..15): memory read latency in cycles.
// Optional feature macro MEM_ARB_RR_EN: when defined, contested grants
// alternate between the ports; when undefined, data wins every contest.
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.slave (fetch, data, memory, busy)
//   dbg_state : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   mem_port_arbiter_if.slave   bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        owner_data_q;   // 0 = fetch owns the access, 1 = data
   logic [63:0] rdata_q;
   logic        if_rvalid_q, d_rvalid_q;
   logic        mem_we_q;
   logic [63:0] mem_addr_q, mem_wdata_q;

   logic        gnt_if, gnt_d;
   logic        fetch_wins;     // fetch takes a contested IDLE cycle
   logic        last_cnt;
   logic        capture;

`ifdef MEM_ARB_RR_EN
   logic        fetch_first_q;

   // Points at the port that should win the next contest: flips to the
   // other port after every grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   fetch_first_q <= 1'b0;
      else if (gnt_d) fetch_first_q <= 1'b1;
      else if (gnt_if) fetch_first_q <= 1'b0;
   end

   assign fetch_wins = fetch_first_q;
`else
   assign fetch_wins = 1'b0;
`endif

   // The counter is loaded with MEM_LAT on the grant edge and decrements from
   // ISSUE onward, so reaching 1 marks the edge where read data is sampled.
   assign last_cnt = (cnt_q == 4'd1);
   assign capture  = !mem_we_q && last_cnt && (state_q == ISSUE || state_q == WAIT);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_d || gnt_if) state_d = ISSUE;
         ISSUE:   if (mem_we_q || last_cnt) state_d = IDLE;
                  else                      state_d = WAIT;
         WAIT:    if (last_cnt) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. Grants are gated by reset_n so nothing is accepted while
   // reset is held, even though the state already reads IDLE.
   always_comb begin
      gnt_d  = 1'b0;
      gnt_if = 1'b0;
      if (reset_n && state_q == IDLE) begin
         if (bus.d_req && (!bus.if_req || !fetch_wins)) gnt_d  = 1'b1;
         else if (bus.if_req)                          gnt_if = 1'b1;
      end
   end

   assign bus.d_gnt  = gnt_d;
   assign bus.if_gnt = gnt_if;
   assign bus.mem_en = (state_q == ISSUE);
   assign bus.busy   = (state_q != IDLE);
   assign dbg_state  = state_q;

   // Request latch, latency counter and read-data capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= 4'd0;
         owner_data_q <= 1'b0;
         rdata_q      <= 64'd0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 64'd0;
         mem_wdata_q  <= 64'd0;
      end else begin
         if_rvalid_q <= capture && !owner_data_q;
         d_rvalid_q  <= capture &&  owner_data_q;
         if (capture) rdata_q <= bus.mem_rdata;

         if (gnt_d) begin
            mem_addr_q   <= bus.d_addr;
            mem_we_q     <= bus.d_we;
            mem_wdata_q  <= bus.d_wdata;
            owner_data_q <= 1'b1;
            cnt_q        <= 4'(MEM_LAT);
         end else if (gnt_if) begin
            // Fetches are always reads; write data is left as it was.
            mem_addr_q   <= bus.if_addr;
            mem_we_q     <= 1'b0;
            owner_data_q <= 1'b0;
            cnt_q        <= 4'(MEM_LAT);
         end else if (state_q != IDLE) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   assign bus.if_rvalid = if_rvalid_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.if_rdata  = rdata_q[31:0];
   assign bus.d_rdata   = rdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles, legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 if_req  input  1  fetch read request; if_addr input 64 fetch byte address.
REQ-005 if_gnt  output  1  fetch request accepted (one-cycle pulse).
REQ-006 if_rvalid  output  1  fetch data valid (one-cycle pulse); if_rdata output 32 instruction word.
REQ-007 d_req  input  1  data request; d_we input 1 write when 1; d_addr input 64; d_wdata input 64.
REQ-008 d_gnt  output  1  data request accepted (one-cycle pulse).
REQ-009 d_rvalid  output  1  load data valid (one-cycle pulse); d_rdata output 64 load data.
REQ-010 mem_en  output  1  memory access strobe; mem_we output 1; mem_addr output 64; mem_wdata output 64.
REQ-011 mem_rdata  input  64  memory read data, valid MEM_LAT cycles after mem_en.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States IDLE, ISSUE, WAIT; exactly one access outstanding at a time.
REQ-014 Requesters hold req and request fields stable until their gnt; gnt is combinational, asserted only in IDLE.
REQ-015 In IDLE with one requester active, that requester is granted in the same cycle.
REQ-016 Contested IDLE cycle: data granted (fixed priority) unless overridden per REQ-029.
REQ-017 On the grant edge: latch addr/we/wdata into mem_addr/mem_we/mem_wdata, record owner, load 4-bit counter with MEM_LAT, go to ISSUE.
REQ-018 ISSUE lasts one cycle with mem_en=1; write goes ISSUE->IDLE with no rvalid; read goes ISSUE->WAIT.
REQ-019 Fetch requests are always reads; if_addr routed as read address.
REQ-020 WAIT: counter decrements each cycle starting in ISSUE; at the edge where counter equals 1, capture mem_rdata, pulse owner rvalid next cycle, go IDLE.
REQ-021 Read latency, grant cycle to rvalid cycle: MEM_LAT+1 cycles; write occupancy: 2 cycles grant to next possible grant.
REQ-022 rvalid cycle is an IDLE cycle; a new grant in that same cycle is legal (back-to-back).
REQ-023 if_rdata = captured mem_rdata[31:0]; d_rdata = captured mem_rdata[63:0]; both hold until next capture.
REQ-024 mem_en=0 outside ISSUE; mem_addr/mem_we/mem_wdata hold last latched values.
REQ-025 Addresses pass unmodified (no alignment check, no wrap handling).

Reset
REQ-026 reset_n low: state IDLE, counter 0, owner fetch, RR pointer data-first, all outputs 0, captured data 0.
REQ-027 Reset mid-access aborts it: no rvalid generated, no gnt during reset.
REQ-028 Release of reset_n: first grant possible in the first clock cycle after release.

Configuration
REQ-029 Macro MEM_ARB_RR_EN defined: contested grants alternate; after a data grant the next contested grant goes to fetch and vice versa; undefined: fixed data priority per REQ-016 (fetch may starve).

Verification
REQ-030 MEM_LAT=2, if_req, if_addr=0x2000, mem_rdata=0x0000_0000_1234_5678 -> if_gnt cycle 0, mem_en cycle 1, if_rvalid cycle 3 with if_rdata=0x12345678.
REQ-031 d_req, d_we=1, d_addr=0x7FFF8, d_wdata=0xDEAD -> d_gnt cycle 0, mem_en=mem_we=1 addr 0x7FFF8 data 0xDEAD cycle 1, no d_rvalid, busy low cycle 2.
REQ-032 if_req and d_req(read) asserted together continuously, no macro -> d_gnt at cycles 0 and 3, if_gnt never; with MEM_ARB_RR_EN -> d_gnt cycle 0, if_gnt cycle 3, d_gnt cycle 6.
REQ-033 Read with MEM_LAT=2, d_req held after grant for a second read -> second d_gnt in the same cycle as first d_rvalid.
REQ-034 reset_n pulsed low during WAIT of a read -> no rvalid, all outputs 0, busy 0; next request granted normally after release.
REQ-035 MEM_LAT=1 read at 0x100 -> rvalid exactly 2 cycles after gnt with correct data.
